obj_pixel_fetch: RTL and testbench
==================================

OBJ_PIXEL_FETCH -- requirements
Module: obj_pixel_fetch

Interface
REQ-001 The module SHALL have parameter CACHE_EN, default 1: 1 enables the one-word fetch cache, 0 forces every request to read VRAM.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clock.
REQ-003 clock  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  pixel request present.
REQ-006 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 req_addr  input  15  OBJ VRAM byte address of the pixel's byte, as produced by the OBJ address unit.
REQ-008 req_palettemode  input  1  1 = 8bpp (256-colour), 0 = 4bpp (16x16).
REQ-009 req_pix_sel  input  1  4bpp nibble select (sprite x[0]): 0 = low nibble, 1 = high nibble; ignored in 8bpp.
REQ-010 req_palbank  input  4  4bpp palette bank; ignored in 8bpp.
REQ-011 flush  input  1  invalidate the fetch cache (VRAM written, new scanline).
REQ-012 vram_rd  output  1  VRAM read strobe.
REQ-013 vram_addr  output  13  VRAM word address (req_addr[14:2]).
REQ-014 vram_ack  input  1  read data valid this cycle.
REQ-015 vram_data  input  32  read word, little-endian byte lanes.
REQ-016 pix_valid  output  1  pixel result present.
REQ-017 pix_ready  input  1  result consumed when pix_valid & pix_ready.
REQ-018 pix_index  output  8  palette index.
REQ-019 pix_transparent  output  1  pixel is colour 0.

Function
REQ-020 The FSM SHALL have states IDLE and READ.
REQ-021 req_ready SHALL be 1 only in IDLE while the output slot is free (pix_valid=0 or pix_ready=1).
REQ-022 In IDLE, on accept with CACHE_EN=1, cache valid, tag == req_addr[14:2] and flush=0, the module SHALL load the result next cycle (hit latency 1) and stay in IDLE.
REQ-023 Any other accept SHALL latch the request, enter READ, and assert vram_rd with vram_addr=req_addr[14:2] from the next cycle.
REQ-024 In READ, vram_rd and vram_addr SHALL be held stable until the cycle vram_ack=1; vram_rd SHALL drop the cycle after the ack.
REQ-025 On vram_ack, the module SHALL store vram_data and the tag, set cache valid, load the result next cycle, and return to IDLE; miss latency = ack cycle + 1.
REQ-026 Byte select SHALL be word[8*addr[1:0] +: 8].
REQ-027 In 8bpp, pix_index SHALL equal the byte, and pix_transparent SHALL equal (byte == 0).
REQ-028 In 4bpp, nib = pix_sel ? byte[7:4] : byte[3:0], pix_index = {palbank, nib}, and pix_transparent = (nib == 0).
REQ-029 pix_valid SHALL stay 1 with pix_index and pix_transparent stable until pix_ready=1; a new result may load in the same cycle as the consume.
REQ-030 flush SHALL clear cache valid at the next edge.
REQ-031 flush in the same cycle as vram_ack SHALL still deliver the fetched pixel, but SHALL leave the cache invalid.
REQ-032 flush in the same cycle as an IDLE accept SHALL force a miss.
REQ-033 vram_ack outside READ SHALL be ignored.
REQ-034 At most one request SHALL be outstanding; no request is accepted in READ.

Reset
REQ-035 After reset: state=IDLE, vram_rd=0, vram_addr=0, pix_valid=0, pix_index=0, pix_transparent=0, cache valid=0, tag=0, and req_ready=1.
REQ-036 Reset asserted in READ SHALL abandon the read: vram_rd=0 the next cycle, and no pix_valid results from a later ack.

Verification
REQ-037 Miss, 8bpp: addr=0x0102, 8bpp, vram_data=0xAABBCCDD acked 3 cycles after vram_rd -> vram_addr=0x0040, then pix_index=0xBB, transparent=0, one cycle after the ack.
REQ-038 Hit, 4bpp: request addr=0x0103, pix_sel=1, palbank=0x5 after REQ-037 -> no vram_rd, next cycle pix_index=0x5A.
REQ-039 Transparent: addr=0x0100, 4bpp, pix_sel=0, word 0x000000F0 -> pix_index=0x?0 with the bank in the upper nibble, transparent=1; same byte in 8bpp -> index=0xF0, transparent=0.
REQ-040 Backpressure: pix_ready=0 for 4 cycles with a result pending -> req_ready=0 and output stable throughout; consume and new accept occur in the same cycle.
REQ-041 Flush: flush with the ack, then rerequest the same word -> second vram_rd issued; flush with an accept of a cached word -> miss.
REQ-042 Reset mid-READ: reset two cycles into READ, then ack -> vram_rd=0 after reset and pix_valid stays 0.

Source files
------------

// File: rtl/obj_pixel_fetch.sv
// obj_pixel_fetch: turns an OBJ VRAM byte address into a palette index.
// A one-word fetch cache short-cuts repeated reads of the same VRAM word;
// misses issue a single word read and wait for the ack.
module obj_pixel_fetch #(
  parameter int CACHE_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [14:0] req_addr,
  input  logic        req_palettemode,
  input  logic        req_pix_sel,
  input  logic [3:0]  req_palbank,
  input  logic        flush,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  input  logic        vram_ack,
  input  logic [31:0] vram_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_index,
  output logic        pix_transparent
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  state_t      state_r;
  logic        cache_valid_r;
  logic [12:0] cache_tag_r;
  logic [31:0] cache_word_r;

  // Request fields held while the VRAM read is in flight.
  logic [1:0]  lat_byte_sel_r;
  logic        lat_mode_r;
  logic        lat_pix_sel_r;
  logic [3:0]  lat_palbank_r;

  logic        slot_free_s;
  logic        accept_s;
  logic        hit_s;
  logic [8:0]  hit_pixel_s;
  logic [8:0]  ack_pixel_s;

  // Decode one pixel from a VRAM word; result is {transparent, index}.
  function automatic logic [8:0] decode_pixel(
    input logic [31:0] word,
    input logic [1:0]  byte_sel,
    input logic        mode_8bpp,
    input logic        pix_sel,
    input logic [3:0]  palbank
  );
    logic [7:0] byte_v;
    logic [3:0] nib_v;
    logic [8:0] res_v;
    case (byte_sel)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    if (pix_sel) begin
      nib_v = byte_v[7:4];
    end else begin
      nib_v = byte_v[3:0];
    end
    if (mode_8bpp) begin
      res_v = {(byte_v == 8'h00), byte_v};
    end else begin
      res_v = {(nib_v == 4'h0), palbank, nib_v};
    end
    return res_v;
  endfunction

  // Handshake decode and cache lookup for the request presented this cycle.
  always_comb begin
    slot_free_s = (~pix_valid) | pix_ready;
    if (state_r == ST_IDLE) begin
      req_ready = slot_free_s;
    end else begin
      req_ready = 1'b0;
    end
    accept_s = req_valid & req_ready;
    // A flush in the accept cycle must not be bypassed by a stale hit.
    hit_s = (CACHE_EN != 0) & cache_valid_r & (cache_tag_r == req_addr[14:2]) & ~flush;
    hit_pixel_s = decode_pixel(cache_word_r, req_addr[1:0], req_palettemode,
                               req_pix_sel, req_palbank);
    ack_pixel_s = decode_pixel(vram_data, lat_byte_sel_r, lat_mode_r,
                               lat_pix_sel_r, lat_palbank_r);
  end

  // Fetch FSM, cache update and registered pixel output slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      vram_rd         <= 1'b0;
      vram_addr       <= 13'd0;
      pix_valid       <= 1'b0;
      pix_index       <= 8'd0;
      pix_transparent <= 1'b0;
      cache_valid_r   <= 1'b0;
      cache_tag_r     <= 13'd0;
      cache_word_r    <= 32'd0;
      lat_byte_sel_r  <= 2'd0;
      lat_mode_r      <= 1'b0;
      lat_pix_sel_r   <= 1'b0;
      lat_palbank_r   <= 4'd0;
    end else begin
      // Consumed results leave the slot; a new load below overrides this.
      if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
      if (flush) begin
        cache_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (hit_s) begin
              pix_valid       <= 1'b1;
              pix_index       <= hit_pixel_s[7:0];
              pix_transparent <= hit_pixel_s[8];
            end else begin
              lat_byte_sel_r <= req_addr[1:0];
              lat_mode_r     <= req_palettemode;
              lat_pix_sel_r  <= req_pix_sel;
              lat_palbank_r  <= req_palbank;
              vram_rd        <= 1'b1;
              vram_addr      <= req_addr[14:2];
              state_r        <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (vram_ack) begin
            vram_rd         <= 1'b0;
            cache_word_r    <= vram_data;
            cache_tag_r     <= vram_addr;
            // The fetched pixel still goes out, but a concurrent flush
            // means the word may already be stale.
            cache_valid_r   <= ~flush;
            pix_valid       <= 1'b1;
            pix_index       <= ack_pixel_s[7:0];
            pix_transparent <= ack_pixel_s[8];
            state_r         <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          vram_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obj_pixel_fetch.sv
// Directed testbench for obj_pixel_fetch with hand-computed expectations.
module tb_obj_pixel_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic        req_palettemode;
  logic        req_pix_sel;
  logic [3:0]  req_palbank;
  logic        flush;
  logic        vram_rd;
  logic [12:0] vram_addr;
  logic        vram_ack;
  logic [31:0] vram_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_index;
  logic        pix_transparent;

  int total = 0;
  int bad   = 0;

  obj_pixel_fetch #(.CACHE_EN(1)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_palettemode (req_palettemode),
    .req_pix_sel     (req_pix_sel),
    .req_palbank     (req_palbank),
    .flush           (flush),
    .vram_rd         (vram_rd),
    .vram_addr       (vram_addr),
    .vram_ack        (vram_ack),
    .vram_data       (vram_data),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_index       (pix_index),
    .pix_transparent (pix_transparent)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [14:0] addr, input logic mode,
                         input logic sel, input logic [3:0] bank);
    req_valid       = 1'b1;
    req_addr        = addr;
    req_palettemode = mode;
    req_pix_sel     = sel;
    req_palbank     = bank;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 15'd0; req_palettemode = 1'b0;
    req_pix_sel = 1'b0; req_palbank = 4'd0; flush = 1'b0; vram_ack = 1'b0;
    vram_data = 32'd0; pix_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_vram_rd", {31'd0, vram_rd}, 32'd0);
    chk("rst_vram_addr", {19'd0, vram_addr}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_pix_index", {24'd0, pix_index}, 32'd0);
    chk("rst_pix_transp", {31'd0, pix_transparent}, 32'd0);

    // Miss, 8bpp, ack on the third vram_rd cycle.
    set_req(15'h0102, 1'b1, 1'b0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("miss_rd_hold", {31'd0, vram_rd}, 32'd1);
      chk("miss_addr_hold", {19'd0, vram_addr}, 32'h0040);
      chk("miss_no_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    chk("miss_rd_ackcyc", {31'd0, vram_rd}, 32'd1);
    vram_ack = 1'b1; vram_data = 32'hAABBCCDD;
    chk("miss_no_pix_yet", {31'd0, pix_valid}, 32'd0);
    tick();
    vram_ack = 1'b0; vram_data = 32'h0;
    chk("miss_pix_valid", {31'd0, pix_valid}, 32'd1);
    chk("miss_pix_index", {24'd0, pix_index}, 32'h00BB);
    chk("miss_pix_transp", {31'd0, pix_transparent}, 32'd0);
    chk("miss_rd_drop", {31'd0, vram_rd}, 32'd0);
    tick();
    chk("miss_consumed", {31'd0, pix_valid}, 32'd0);

    // Hit, 4bpp high nibble of byte 3.
    set_req(15'h0103, 1'b0, 1'b1, 4'h5);
    tick();
    req_valid = 1'b0;
    chk("hit_no_rd", {31'd0, vram_rd}, 32'd0);
    chk("hit_pix_valid", {31'd0, pix_valid}, 32'd1);
    chk("hit_pix_index", {24'd0, pix_index}, 32'h005A);
    chk("hit_pix_transp", {31'd0, pix_transparent}, 32'd0);
    tick();

    // Idle flush, then transparent 4bpp pixel from a fresh word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_req(15'h0100, 1'b0, 1'b0, 4'h3);
    tick();
    req_valid = 1'b0;
    chk("tr_miss_rd", {31'd0, vram_rd}, 32'd1);
    vram_ack = 1'b1; vram_data = 32'h000000F0;
    tick();
    vram_ack = 1'b0;
    chk("tr4_index", {24'd0, pix_index}, 32'h0030);
    chk("tr4_transp", {31'd0, pix_transparent}, 32'd1);
    tick();
    set_req(15'h0100, 1'b1, 1'b0, 4'h3);
    tick();
    req_valid = 1'b0;
    chk("tr8_no_rd", {31'd0, vram_rd}, 32'd0);
    chk("tr8_index", {24'd0, pix_index}, 32'h00F0);
    chk("tr8_transp", {31'd0, pix_transparent}, 32'd0);
    tick();

    // Backpressure: result held for 4 cycles, then consume + accept together.
    pix_ready = 1'b0;
    set_req(15'h0100, 1'b0, 1'b1, 4'h7);
    tick();
    set_req(15'h0100, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
      chk("bp_valid", {31'd0, pix_valid}, 32'd1);
      chk("bp_index", {24'd0, pix_index}, 32'h007F);
      chk("bp_transp", {31'd0, pix_transparent}, 32'd0);
      tick();
    end
    pix_ready = 1'b1;
    #1;
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_new_valid", {31'd0, pix_valid}, 32'd1);
    chk("bp_new_index", {24'd0, pix_index}, 32'h00F0);
    tick();

    // Flush together with the ack leaves the cache invalid.
    set_req(15'h0200, 1'b1, 1'b0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("fa_rd", {31'd0, vram_rd}, 32'd1);
    chk("fa_addr", {19'd0, vram_addr}, 32'h0080);
    vram_ack = 1'b1; flush = 1'b1; vram_data = 32'h11223344;
    tick();
    vram_ack = 1'b0; flush = 1'b0;
    chk("fa_pix_valid", {31'd0, pix_valid}, 32'd1);
    chk("fa_pix_index", {24'd0, pix_index}, 32'h0044);
    tick();
    set_req(15'h0201, 1'b1, 1'b0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("fa_reread_rd", {31'd0, vram_rd}, 32'd1);
    vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    chk("fa_reread_index", {24'd0, pix_index}, 32'h0033);
    tick();

    // Flush together with an accept of a cached word forces a miss.
    set_req(15'h0202, 1'b1, 1'b0, 4'h0);
    flush = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("fx_miss_rd", {31'd0, vram_rd}, 32'd1);
    chk("fx_no_pix", {31'd0, pix_valid}, 32'd0);
    vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    chk("fx_index", {24'd0, pix_index}, 32'h0022);
    tick();
    set_req(15'h0203, 1'b1, 1'b0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("fx_hit_no_rd", {31'd0, vram_rd}, 32'd0);
    chk("fx_hit_index", {24'd0, pix_index}, 32'h0011);
    tick();

    // Stray ack while idle is ignored.
    vram_ack = 1'b1;
    tick();
    vram_ack = 1'b0;
    chk("stray_ack_pix", {31'd0, pix_valid}, 32'd0);
    chk("stray_ack_rd", {31'd0, vram_rd}, 32'd0);

    // Reset two cycles into READ abandons the read.
    set_req(15'h0300, 1'b1, 1'b0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("rr_rd", {31'd0, vram_rd}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_rd_off", {31'd0, vram_rd}, 32'd0);
    chk("rr_ready", {31'd0, req_ready}, 32'd1);
    vram_ack = 1'b1; vram_data = 32'h99887766;
    tick();
    vram_ack = 1'b0;
    chk("rr_no_pix", {31'd0, pix_valid}, 32'd0);
    chk("rr_no_rd", {31'd0, vram_rd}, 32'd0);
    tick();
    chk("rr_no_pix2", {31'd0, pix_valid}, 32'd0);
    // Cache was cleared by reset: a formerly cached word misses.
    set_req(15'h0203, 1'b1, 1'b0, 4'h0);
    tick();
    req_valid = 1'b0;
    chk("rr_cache_cleared", {31'd0, vram_rd}, 32'd1);
    vram_ack = 1'b1; vram_data = 32'h11223344;
    tick();
    vram_ack = 1'b0;
    chk("rr_final_index", {24'd0, pix_index}, 32'h0011);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
